// File: rtl/sram_clear_ctrl.sv
// Clears an external no-init SRAM by sweeping every address with FILL after reset or clear_req.
// Outside a sweep the client passes through with zero added latency; client accesses during a sweep are dropped.
module sram_clear_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] FILL       = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_data,
  input  logic                  c_cen,
  input  logic                  c_we,
  output logic [DATA_WIDTH-1:0] c_q,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cen,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_rd_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= CLEAR;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_rd_clr <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_rd_clr <= (r_state == CLEAR);
    end
  end

  // The sweep ends on the last address rather than on counter wrap, so exactly one pass is issued.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b1;
      end
    endcase
  end

  always_comb begin
    ram_addr = c_addr;
    ram_data = c_data;
    ram_cen  = c_cen;
    ram_we   = c_we;
    if (r_state == CLEAR) begin
      ram_addr = r_cnt;
      ram_data = FILL;
      ram_cen  = 1'b1;
      ram_we   = 1'b1;
    end
  end

  // Reads issued during a sweep see FILL, since the RAM word may not be written yet.
  assign c_q  = r_rd_clr ? FILL : ram_q;
  assign busy = r_busy;
  assign done = r_done;

endmodule
